bj_game_ctrl: RTL and testbench

Game-sequencing controller for the BlackJack board design. It debounces nothing; it edge-detects the deal/hit/stand keys and samples the free-running 1–10 card counter at draw time. It accumulates player and dealer hand sums, runs the dealer's draw-to-threshold policy, and reports the round result. It sits between the KEY inputs and the card counter output on one side, and the hex7seg display and LEDR outputs on the other.

---
 rtl/bj_game_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_bj_game_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bj_game_ctrl.sv
// bj_game_ctrl: round sequencer for the BlackJack board.
//
// Synchronises and edge-detects the deal/hit/stand keys, samples the free-running 1..10
// card counter when a card is drawn, accumulates player and dealer hand sums, runs the
// dealer draw-to-threshold policy and reports the round outcome.
//
// Optional feature macro: BJ_SOFT_ACE_EN. When defined, an ace may count as 11: each hand
// tracks a has-ace flag and the reported sum is hard+10 whenever that does not exceed 21.
//
// Ports:
//   clock_i        system clock
//   reset_ni       asynchronous active-low reset
//   deal_ni        deal key, active low, asynchronous
//   hit_ni         hit key, active low, asynchronous
//   stand_ni       stand key, active low, asynchronous
//   card_i         card counter value, valid range 1..10
//   player_sum_o   player hand value
//   dealer_sum_o   dealer hand value
//   state_out_o    FSM state code (IDLE=0 .. RESULT=8)
//   player_turn_o  high in PLAYER
//   win_o/lose_o/push_o  round outcome, valid only in RESULT
module bj_game_ctrl #(
  parameter int unsigned DEALER_STAND = 17,
  parameter int unsigned DRAW_GAP     = 13
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       deal_ni,
  input  logic       hit_ni,
  input  logic       stand_ni,
  input  logic [3:0] card_i,
  output logic [4:0] player_sum_o,
  output logic [4:0] dealer_sum_o,
  output logic [3:0] state_out_o,
  output logic       player_turn_o,
  output logic       win_o,
  output logic       lose_o,
  output logic       push_o
);

  localparam int unsigned GapW    = (DRAW_GAP > 2) ? $clog2(DRAW_GAP) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(DRAW_GAP - 1);
  localparam logic [4:0]      StandTh = 5'(DEALER_STAND);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StDealP1 = 4'd1,
    StDealD1 = 4'd2,
    StDealP2 = 4'd3,
    StPlayer = 4'd4,
    StPDraw  = 4'd5,
    StDealer = 4'd6,
    StDDraw  = 4'd7,
    StResult = 4'd8
  } state_e;

  state_e state_q, state_d;

  // Key synchronisers, bit order {stand, hit, deal}; reset to released (1).
  logic [2:0] key_s1_q, key_s2_q, key_prev_q, key_pulse;
  logic       deal_pulse, hit_pulse, stand_pulse;

  logic [GapW-1:0] gap_q, gap_d;
  logic            gap_zero;

  logic [4:0] p_hard_q, d_hard_q;
  logic [4:0] p_new_hard, d_new_hard;
  logic [4:0] p_sum, d_sum, p_new_sum;
  logic       hand_clr, p_load, d_load;
  logic       card_ok;

  logic win_q, win_d, lose_q, lose_d, push_q, push_d;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      key_s1_q   <= 3'b111;
      key_s2_q   <= 3'b111;
      key_prev_q <= 3'b111;
    end else begin
      key_s1_q   <= {stand_ni, hit_ni, deal_ni};
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  // Falling edge of the synchronised level: one pulse per press, none while held.
  assign key_pulse   = key_prev_q & ~key_s2_q;
  assign deal_pulse  = key_pulse[0];
  assign hit_pulse   = key_pulse[1];
  assign stand_pulse = key_pulse[2];

  assign card_ok    = (card_i != 4'd0) && (card_i <= 4'd10);
  assign gap_zero   = (gap_q == '0);
  assign p_new_hard = p_hard_q + {1'b0, card_i};
  assign d_new_hard = d_hard_q + {1'b0, card_i};

`ifdef BJ_SOFT_ACE_EN
  logic p_ace_q, d_ace_q;
  logic card_is_ace;

  assign card_is_ace = (card_i == 4'd1);

  function automatic logic [4:0] soft_sum(input logic [4:0] hard, input logic ace);
    return (ace && (hard <= 5'd11)) ? hard + 5'd10 : hard;
  endfunction

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      p_ace_q <= 1'b0;
      d_ace_q <= 1'b0;
    end else if (hand_clr) begin
      p_ace_q <= 1'b0;
      d_ace_q <= 1'b0;
    end else begin
      if (p_load && card_is_ace) p_ace_q <= 1'b1;
      if (d_load && card_is_ace) d_ace_q <= 1'b1;
    end
  end

  assign p_sum     = soft_sum(p_hard_q, p_ace_q);
  assign d_sum     = soft_sum(d_hard_q, d_ace_q);
  assign p_new_sum = soft_sum(p_new_hard, p_ace_q | card_is_ace);
`else
  assign p_sum     = p_hard_q;
  assign d_sum     = d_hard_q;
  assign p_new_sum = p_new_hard;
`endif

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_zero ? gap_q : gap_q - 1'b1;
    hand_clr = 1'b0;
    p_load   = 1'b0;
    d_load   = 1'b0;
    win_d    = win_q;
    lose_d   = lose_q;
    push_d   = push_q;

    unique case (state_q)
      StIdle, StResult: begin
        if (deal_pulse) begin
          hand_clr = 1'b1;
          gap_d    = '0;
          win_d    = 1'b0;
          lose_d   = 1'b0;
          push_d   = 1'b0;
          state_d  = StDealP1;
        end
      end
      StDealP1: begin
        if (gap_zero && card_ok) begin
          p_load  = 1'b1;
          gap_d   = GapLoad;
          state_d = StDealD1;
        end
      end
      StDealD1: begin
        if (gap_zero && card_ok) begin
          d_load  = 1'b1;
          gap_d   = GapLoad;
          state_d = StDealP2;
        end
      end
      StDealP2: begin
        if (gap_zero && card_ok) begin
          p_load  = 1'b1;
          gap_d   = GapLoad;
          state_d = (p_new_sum == 5'd21) ? StDealer : StPlayer;
        end
      end
      StPlayer: begin
        if (stand_pulse)    state_d = StDealer;
        else if (hit_pulse) state_d = StPDraw;
      end
      StPDraw: begin
        // Player draws are key-paced, so the gap counter is neither checked nor reloaded.
        if (card_ok) begin
          p_load = 1'b1;
          if (p_new_sum > 5'd21) begin
            lose_d  = 1'b1;
            state_d = StResult;
          end else if (p_new_sum == 5'd21) begin
            state_d = StDealer;
          end else begin
            state_d = StPlayer;
          end
        end
      end
      StDealer: begin
        if (d_sum >= StandTh) begin
          state_d = StResult;
          if (p_sum > 5'd21)      lose_d = 1'b1;
          else if (d_sum > 5'd21) win_d  = 1'b1;
          else if (p_sum > d_sum) win_d  = 1'b1;
          else if (p_sum < d_sum) lose_d = 1'b1;
          else                    push_d = 1'b1;
        end else begin
          state_d = StDDraw;
        end
      end
      StDDraw: begin
        if (gap_zero && card_ok) begin
          d_load  = 1'b1;
          gap_d   = GapLoad;
          state_d = StDealer;
        end
      end
      default: begin
        state_d = StIdle;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        push_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      p_hard_q <= '0;
      d_hard_q <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      push_q  <= push_d;
      if (hand_clr) begin
        p_hard_q <= '0;
        d_hard_q <= '0;
      end else begin
        if (p_load) p_hard_q <= p_new_hard;
        if (d_load) d_hard_q <= d_new_hard;
      end
    end
  end

  assign player_sum_o  = p_sum;
  assign dealer_sum_o  = d_sum;
  assign state_out_o   = state_q;
  assign player_turn_o = (state_q == StPlayer);
  assign win_o         = win_q;
  assign lose_o        = lose_q;
  assign push_o        = push_q;

endmodule

// File: tb/tb_bj_game_ctrl.sv
// Self-checking bench for bj_game_ctrl: directed scenarios plus randomised rounds scored
// against a hand-level model of the game rules.
module tb_bj_game_ctrl;

  logic       clock = 1'b0;
  logic       reset_n, deal_n, hit_n, stand_n;
  logic [3:0] card;
  logic [4:0] player_sum, dealer_sum;
  logic [3:0] state_out;
  logic       player_turn, win, lose, push;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the current round.
  int p_hard, d_hard;
  bit p_ace, d_ace;

  bj_game_ctrl dut (
    .clock_i      (clock),
    .reset_ni     (reset_n),
    .deal_ni      (deal_n),
    .hit_ni       (hit_n),
    .stand_ni     (stand_n),
    .card_i       (card),
    .player_sum_o (player_sum),
    .dealer_sum_o (dealer_sum),
    .state_out_o  (state_out),
    .player_turn_o(player_turn),
    .win_o        (win),
    .lose_o       (lose),
    .push_o       (push)
  );

  always #5 clock = ~clock;

  function automatic int rep(input int hard, input bit ace);
`ifdef BJ_SOFT_ACE_EN
    if (ace && hard + 10 <= 21) return hard + 10;
`endif
    return hard;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold the selected keys low across exactly one clock edge.
  task automatic pulse_keys(input bit d, input bit h, input bit s);
    deal_n  = !d;
    hit_n   = !h;
    stand_n = !s;
    tick();
    deal_n  = 1'b1;
    hit_n   = 1'b1;
    stand_n = 1'b1;
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_out == code) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (state_out == code) ok = 1'b1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    deal_n  = 1'b1;
    hit_n   = 1'b1;
    stand_n = 1'b1;
    card    = 4'd5;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Deal with the card bus held at a, leaving the DUT in PLAYER.
  task automatic deal_const(input int a);
    bit ok;
    card = 4'(a);
    pulse_keys(1, 0, 0);
    wait_state(4'd4, 200, ok);
    p_hard = 2 * a;
    p_ace  = (a == 1);
    d_hard = a;
    d_ace  = (a == 1);
    n_checks++;
    if (!ok || player_sum !== 5'(rep(p_hard, p_ace)) || dealer_sum !== 5'(rep(d_hard, d_ace)))
      $display("FAIL deal_const(%0d): state=%0d p=%0d d=%0d want state=4 p=%0d d=%0d", a,
               state_out, player_sum, dealer_sum, rep(p_hard, p_ace), rep(d_hard, d_ace));
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    deal_n  = 1'b1;
    hit_n   = 1'b1;
    stand_n = 1'b1;
    card    = 4'd0;
    tick();
    n_checks++;
    if ({player_sum, dealer_sum, state_out} !== 14'd0)
      $display("FAIL reset_sums_state: p=%0d d=%0d s=%0d want 0", player_sum, dealer_sum,
               state_out);
    else n_pass++;
    n_checks++;
    if ({player_turn, win, lose, push} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {player_turn, win, lose, push});
    else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  // Exact deal latency and card spacing with the card held at 5.
  task automatic test_deal();
    card = 4'd5;
    pulse_keys(1, 0, 0);         // now just past edge N
    tick();                      // N+1
    tick();                      // N+2
    n_checks++;
    if (state_out !== 4'd1 || player_sum !== 5'd0)
      $display("FAIL deal_n2: state=%0d p=%0d want 1/0", state_out, player_sum);
    else n_pass++;
    tick();                      // N+3
    n_checks++;
    if (state_out !== 4'd2 || player_sum !== 5'd5)
      $display("FAIL deal_n3: state=%0d p=%0d want 2/5", state_out, player_sum);
    else n_pass++;
    repeat (12) tick();          // N+15
    n_checks++;
    if (dealer_sum !== 5'd0) $display("FAIL deal_gap_d: d=%0d want 0", dealer_sum);
    else n_pass++;
    tick();                      // N+16
    n_checks++;
    if (dealer_sum !== 5'd5 || state_out !== 4'd3)
      $display("FAIL deal_n16: d=%0d state=%0d want 5/3", dealer_sum, state_out);
    else n_pass++;
    repeat (12) tick();          // N+28
    n_checks++;
    if (player_sum !== 5'd5) $display("FAIL deal_gap_p: p=%0d want 5", player_sum);
    else n_pass++;
    tick();                      // N+29
    n_checks++;
    if (player_sum !== 5'd10 || dealer_sum !== 5'd5 || state_out !== 4'd4 || !player_turn)
      $display("FAIL deal_done: p=%0d d=%0d state=%0d turn=%b want 10/5/4/1", player_sum,
               dealer_sum, state_out, player_turn);
    else n_pass++;
  endtask

  task automatic test_hit_bust();
    card = 4'd5;
    pulse_keys(0, 1, 0);
    tick();
    tick();                      // N+2
    n_checks++;
    if (state_out !== 4'd5 || player_sum !== 5'd10)
      $display("FAIL hit_n2: state=%0d p=%0d want 5/10", state_out, player_sum);
    else n_pass++;
    tick();                      // N+3
    n_checks++;
    if (state_out !== 4'd4 || player_sum !== 5'd15)
      $display("FAIL hit_n3: state=%0d p=%0d want 4/15", state_out, player_sum);
    else n_pass++;
    card = 4'd10;
    pulse_keys(0, 1, 0);
    repeat (3) tick();
    n_checks++;
    if (player_sum !== 5'd25 || state_out !== 4'd8 || {win, lose, push} !== 3'b010)
      $display("FAIL hit_bust: p=%0d state=%0d wlp=%b want 25/8/010", player_sum, state_out,
               {win, lose, push});
    else n_pass++;
  endtask

  task automatic test_dealer_stand();
    bit ok;
    for (int k = 0; k < 2; k++) begin
      deal_const(5);
      card = (k == 0) ? 4'd7 : 4'd8;
      pulse_keys(0, 1, 0);
      repeat (3) tick();
      card = 4'd6;
      pulse_keys(0, 0, 1);
      wait_state(4'd8, 300, ok);
      n_checks++;
      if (!ok || dealer_sum !== 5'd17 || {win, lose, push} !== ((k == 0) ? 3'b001 : 3'b100))
        $display("FAIL dealer_17_k%0d: state=%0d d=%0d wlp=%b want 8/17/%b", k, state_out,
                 dealer_sum, {win, lose, push}, (k == 0) ? 3'b001 : 3'b100);
      else n_pass++;
    end
  endtask

  task automatic test_hit_stand_same();
    bit ok;
    deal_const(5);
    card = 4'd10;
    pulse_keys(0, 1, 1);
    tick();
    tick();
    n_checks++;
    if (state_out !== 4'd6 || player_sum !== 5'd10)
      $display("FAIL hit_stand_same: state=%0d p=%0d want 6/10", state_out, player_sum);
    else n_pass++;
    wait_state(4'd8, 300, ok);
    n_checks++;
    if (!ok || dealer_sum !== 5'd25 || {win, lose, push} !== 3'b100)
      $display("FAIL dealer_bust: state=%0d d=%0d wlp=%b want 8/25/100", state_out,
               dealer_sum, {win, lose, push});
    else n_pass++;
    // A held key yields one draw only.
    deal_const(2);
    hit_n = 1'b0;
    repeat (1000) tick();
    hit_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (player_sum !== 5'd6 || state_out !== 4'd4)
      $display("FAIL hold_hit: p=%0d state=%0d want 6/4", player_sum, state_out);
    else n_pass++;
  endtask

  task automatic test_invalid_card();
    card = 4'd0;
    pulse_keys(0, 1, 0);
    repeat (25) tick();
    n_checks++;
    if (state_out !== 4'd5 || player_sum !== 5'd6)
      $display("FAIL card0_wait: state=%0d p=%0d want 5/6", state_out, player_sum);
    else n_pass++;
    card = 4'd11;
    repeat (25) tick();
    n_checks++;
    if (state_out !== 4'd5 || player_sum !== 5'd6)
      $display("FAIL card11_wait: state=%0d p=%0d want 5/6", state_out, player_sum);
    else n_pass++;
    card = 4'd3;
    tick();
    n_checks++;
    if (state_out !== 4'd4 || player_sum !== 5'd9)
      $display("FAIL card3_draw: state=%0d p=%0d want 4/9", state_out, player_sum);
    else n_pass++;
  endtask

  // Deal 1,4,6 then hit 10; then abort the round from inside D_DRAW.
  task automatic test_ace_and_abort();
    apply_reset();
    card = 4'd1;
    pulse_keys(1, 0, 0);
    repeat (3) tick();           // N+3: player takes the ace
    card = 4'd4;
    repeat (13) tick();          // N+16: dealer takes 4
    card = 4'd6;
    repeat (13) tick();          // N+29: player takes 6
    n_checks++;
    if (player_sum !== 5'(rep(7, 1)) || state_out !== 4'd4)
      $display("FAIL ace_deal: p=%0d state=%0d want %0d/4", player_sum, state_out, rep(7, 1));
    else n_pass++;
    card = 4'd10;
    pulse_keys(0, 1, 0);
    repeat (3) tick();
    n_checks++;
    if (player_sum !== 5'(rep(17, 1)) || state_out !== 4'd4)
      $display("FAIL ace_hit10: p=%0d state=%0d want %0d/4", player_sum, state_out,
               rep(17, 1));
    else n_pass++;
    card = 4'd0;
    pulse_keys(0, 0, 1);
    repeat (5) tick();
    n_checks++;
    if (state_out !== 4'd7) $display("FAIL abort_setup: state=%0d want 7", state_out);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({player_sum, dealer_sum, state_out, player_turn, win, lose, push} !== 18'd0)
      $display("FAIL abort_reset: p=%0d d=%0d s=%0d flags=%b want all 0", player_sum,
               dealer_sum, state_out, {player_turn, win, lose, push});
    else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random_rounds();
    bit ok, done;
    int h, dc, pv, dv;
    logic [2:0] exp_flags;
    for (int r = 0; r < 20; r++) begin
      deal_const($urandom_range(1, 10));
      done = 1'b0;
      dc   = $urandom_range(1, 10);
      // Player hits while under 17 (mostly), each card fixed on the bus before the press.
      while (!done && rep(p_hard, p_ace) < 17 && $urandom_range(0, 3) != 0) begin
        h    = $urandom_range(1, 10);
        card = 4'(h);
        pulse_keys(0, 1, 0);
        repeat (3) tick();
        p_hard += h;
        p_ace  |= (h == 1);
        pv = rep(p_hard, p_ace);
        n_checks++;
        if (player_sum !== 5'(pv))
          $display("FAIL rnd%0d_hit: p=%0d want %0d", r, player_sum, pv);
        else n_pass++;
        if (pv >= 21) begin
          done = 1'b1;
          dc   = h;            // auto-stand: dealer draws whatever is on the bus
        end
      end
      if (rep(p_hard, p_ace) < 21) begin
        card = 4'(dc);
        pulse_keys(0, 0, 1);
      end
      pv = rep(p_hard, p_ace);
      if (pv <= 21) begin
        while (rep(d_hard, d_ace) < 17) begin
          d_hard += dc;
          d_ace  |= (dc == 1);
        end
      end
      dv = rep(d_hard, d_ace);
      if (pv > 21)      exp_flags = 3'b010;
      else if (dv > 21) exp_flags = 3'b100;
      else if (pv > dv) exp_flags = 3'b100;
      else if (pv < dv) exp_flags = 3'b010;
      else              exp_flags = 3'b001;
      wait_state(4'd8, 400, ok);
      n_checks++;
      if (!ok || player_sum !== 5'(pv) || dealer_sum !== 5'(dv) ||
          {win, lose, push} !== exp_flags)
        $display("FAIL rnd%0d_result: s=%0d p=%0d d=%0d wlp=%b want 8/%0d/%0d/%b", r,
                 state_out, player_sum, dealer_sum, {win, lose, push}, pv, dv, exp_flags);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_deal();
    test_hit_bust();
    test_dealer_stand();
    test_hit_stand_same();
    test_invalid_card();
    test_ace_and_abort();
    test_random_rounds();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
